// File: rtl/requant_pkg.sv
// Shared widths, clamp bounds, parameter-entry struct and rounding helper for requant_pipe.
package requant_pkg;

  localparam int ACC_W      = 32;
  localparam int SUM_W      = 33;
  localparam int SCALE_BITS = 16;
  localparam int SHIFT_BITS = 5;
  localparam int ZP_BITS    = 8;
  localparam int PROD_W     = SUM_W + SCALE_BITS + 1;
  localparam int VAL_W      = PROD_W + 1;

  localparam logic signed [VAL_W-1:0] CLAMP_HI = VAL_W'(64'sh7FFF_FFFF);
  localparam logic signed [VAL_W-1:0] CLAMP_LO = VAL_W'(-64'sh8000_0000);

  typedef struct packed {
    logic signed [ACC_W-1:0] bias;
    logic [SCALE_BITS-1:0]   scale;
    logic [SHIFT_BITS-1:0]   shift;
    logic [ZP_BITS-1:0]      zp;
  } param_t;

  // Arithmetic right shift rounding half toward +inf; the product never
  // comes close enough to the PROD_W limit for the +half to overflow.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [SHIFT_BITS-1:0]    sh
  );
    logic signed [PROD_W-1:0] half;
    logic signed [PROD_W-1:0] res;
    half = '0;
    if (sh == '0) begin
      res = p;
    end else begin
      half[sh - SHIFT_BITS'(1)] = 1'b1;
      res = (p + half) >>> sh;
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_param_table.sv
// Per-channel parameter register file: one write port, one combinational read port.
// Writes land on the clock edge, so a same-cycle read returns the previous entry.
module requant_param_table
  import requant_pkg::*;
#(
  parameter int CH_NUM = 8,
  parameter int CH_W   = $clog2(CH_NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_addr,
  input  param_t          wr_data,
  input  logic [CH_W-1:0] rd_addr,
  output param_t          rd_data
);

  param_t tbl [CH_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  assign rd_data = tbl[rd_addr];

endmodule

// File: rtl/requant_pipe.sv
// Per-channel requantisation: bias add, scale, rounding shift, zero-point add, clamp to s32.
// Latency 4 cycles, one beat per cycle; no backpressure (downstream always accepts).
module requant_pipe
  import requant_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int SCALE_W = SCALE_BITS,
  parameter int SHIFT_W = SHIFT_BITS,
  parameter int ZP_W    = ZP_BITS,
  localparam int CH_W   = $clog2(CH_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               param_wr_en,
  input  logic [CH_W-1:0]    param_addr,
  input  logic [31:0]        param_bias,
  input  logic [SCALE_W-1:0] param_scale,
  input  logic [SHIFT_W-1:0] param_shift,
  input  logic [ZP_W-1:0]    param_zp,
  input  logic               frame_start,
  input  logic               data_in_valid,
  input  logic [31:0]        data_in,
  output logic               data_out_valid,
  output logic [31:0]        data_out,
  output logic [CH_W-1:0]    data_out_ch
);

  param_t wr_ent;
  param_t rd_ent;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] beat_ch;

  assign wr_ent  = '{bias: param_bias, scale: param_scale, shift: param_shift, zp: param_zp};
  assign beat_ch = frame_start ? '0 : ch_q;

  requant_param_table #(.CH_NUM(CH_NUM)) u_tbl (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (param_wr_en),
    .wr_addr (param_addr),
    .wr_data (wr_ent),
    .rd_addr (beat_ch),
    .rd_data (rd_ent)
  );

  // Counter width equals log2(CH_NUM), so +1 wraps to 0 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ch_q <= '0;
    else if (data_in_valid) ch_q <= beat_ch + CH_W'(1);
  end

  logic                     v1, v2, v3;
  logic signed [SUM_W-1:0]  sum1;
  logic [SCALE_BITS-1:0]    scale1;
  logic [SHIFT_BITS-1:0]    shift1, shift2;
  logic [ZP_BITS-1:0]       zp1, zp2, zp3;
  logic [CH_W-1:0]          ch1, ch2, ch3;
  logic signed [PROD_W-1:0] prod2, r3;
  logic signed [VAL_W-1:0]  v_sum;
  logic [31:0]              v_clamp;

  always_comb begin
    v_sum = VAL_W'(r3) + VAL_W'($signed({1'b0, zp3}));
    if (v_sum > CLAMP_HI)      v_clamp = 32'h7FFF_FFFF;
    else if (v_sum < CLAMP_LO) v_clamp = 32'h8000_0000;
    else                       v_clamp = v_sum[31:0];
  end

  // Parameters are captured at S1 and travel with the beat, so table writes
  // never disturb beats already in the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      sum1 <= '0; scale1 <= '0; shift1 <= '0; zp1 <= '0; ch1 <= '0;
      prod2 <= '0; shift2 <= '0; zp2 <= '0; ch2 <= '0;
      r3 <= '0; zp3 <= '0; ch3 <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_ch    <= '0;
    end else begin
      v1 <= data_in_valid;
      v2 <= v1;
      v3 <= v2;
      data_out_valid <= v3;
      if (data_in_valid) begin
        sum1   <= SUM_W'($signed(data_in)) + SUM_W'(rd_ent.bias);
        scale1 <= rd_ent.scale;
        shift1 <= rd_ent.shift;
        zp1    <= rd_ent.zp;
        ch1    <= beat_ch;
      end
      if (v1) begin
        prod2  <= PROD_W'(sum1) * PROD_W'($signed({1'b0, scale1}));
        shift2 <= shift1;
        zp2    <= zp1;
        ch2    <= ch1;
      end
      if (v2) begin
        r3  <= round_shift(prod2, shift2);
        zp3 <= zp2;
        ch3 <= ch2;
      end
      if (v3) begin
        data_out    <= v_clamp;
        data_out_ch <= ch3;
      end
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Directed + randomized bench for requant_pipe against an integer-arithmetic reference model.
module tb_requant_pipe;

  logic        clk;
  logic        rst_n;
  logic        param_wr_en;
  logic [2:0]  param_addr;
  logic [31:0] param_bias;
  logic [15:0] param_scale;
  logic [4:0]  param_shift;
  logic [7:0]  param_zp;
  logic        frame_start;
  logic        data_in_valid;
  logic [31:0] data_in;
  logic        data_out_valid;
  logic [31:0] data_out;
  logic [2:0]  data_out_ch;

  requant_pipe #(.CH_NUM(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .param_wr_en    (param_wr_en),
    .param_addr     (param_addr),
    .param_bias     (param_bias),
    .param_scale    (param_scale),
    .param_shift    (param_shift),
    .param_zp       (param_zp),
    .frame_start    (frame_start),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .data_out_ch    (data_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
    int          ch;
  } exp_t;

  int          ncmp = 0;
  int          nfail = 0;
  int          ecnt = 0;
  int          mch = 0;
  exp_t        q[$];
  logic [31:0] last_d;
  int          last_ch;
  bit          ev;
  string       tag;

  int          m_bias [8];
  int unsigned m_scale[8];
  int          m_shift[8];
  int          m_zp   [8];

  bit          pw;
  int          pa;
  logic [31:0] pbias;
  int unsigned pscale;
  int          pshift;
  int          pzp;

  int          nd[3];
  int          ne[3];

  function automatic logic [31:0] model(input logic [31:0] din, input int ch);
    longint s, p, r, v;
    s = longint'($signed(din)) + longint'(m_bias[ch]);
    p = s * longint'(m_scale[ch]);
    if (m_shift[ch] == 0) r = p;
    else r = (p + (longint'(1) << (m_shift[ch] - 1))) >>> m_shift[ch];
    v = r + longint'(m_zp[ch]);
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s.%s got=%h want=%h", tag, name, got, exp);
    end
  endtask

  task automatic set_wr(input int a, input logic [31:0] b, input int unsigned s,
                        input int sh, input int z);
    pw = 1'b1; pa = a; pbias = b; pscale = s; pshift = sh; pzp = z;
  endtask

  task automatic model_clear();
    q.delete();
    last_d = '0; last_ch = 0; mch = 0;
    for (int i = 0; i < 8; i++) begin
      m_bias[i] = 0; m_scale[i] = 0; m_shift[i] = 0; m_zp[i] = 0;
    end
  endtask

  // One clock: drive a beat (and any pending param write), then check outputs.
  task automatic cyc(input bit v, input bit fs, input logic [31:0] din);
    exp_t e;
    int   bc;
    @(negedge clk);
    data_in_valid = v;
    frame_start   = fs;
    data_in       = din;
    param_wr_en   = pw;
    param_addr    = 3'(pa);
    param_bias    = pbias;
    param_scale   = 16'(pscale);
    param_shift   = 5'(pshift);
    param_zp      = 8'(pzp);
    if (v) begin
      bc    = fs ? 0 : mch;
      e.due = ecnt + 4;
      e.d   = model(din, bc);
      e.ch  = bc;
      q.push_back(e);
      mch = (bc + 1) % 8;
    end
    if (pw) begin
      m_bias[pa]  = $signed(pbias);
      m_scale[pa] = pscale;
      m_shift[pa] = pshift;
      m_zp[pa]    = pzp;
    end
    pw = 1'b0;
    @(posedge clk);
    #1;
    ecnt++;
    ev = 1'b0;
    if (q.size() > 0 && q[0].due == ecnt) begin
      ev      = 1'b1;
      last_d  = q[0].d;
      last_ch = q[0].ch;
      void'(q.pop_front());
    end
    chk("vld", 32'(data_out_valid), 32'(ev));
    chk("dat", data_out, last_d);
    chk("ch", 32'(data_out_ch), 32'(last_ch));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_in_valid = 1'b0; frame_start = 1'b0; param_wr_en = 1'b0; pw = 1'b0;
    model_clear();
    #1;
    chk("rst_vld", 32'(data_out_valid), 32'd0);
    chk("rst_dat", data_out, 32'd0);
    chk("rst_ch", 32'(data_out_ch), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_vld", 32'(data_out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    param_wr_en = 1'b0; param_addr = '0; param_bias = '0; param_scale = '0;
    param_shift = '0; param_zp = '0; frame_start = 1'b0; data_in_valid = 1'b0;
    data_in = '0;
    pw = 1'b0; pa = 0; pbias = '0; pscale = 0; pshift = 0; pzp = 0;
    model_clear();

    tag = "reset";
    repeat (2) @(posedge clk);
    #1;
    chk("vld", 32'(data_out_valid), 32'd0);
    chk("dat", data_out, 32'd0);
    chk("ch", 32'(data_out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    tag = "basic";
    set_wr(0, 32'd28, 2, 1, 0);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'd100);
    idle(4);
    chk("const", data_out, 32'd128);

    tag = "neg_round";
    nd = '{-5, -4, 3};
    ne = '{-2, -2, 2};
    set_wr(0, 32'd0, 1, 1, 0);
    cyc(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 32'(nd[i]));
      idle(4);
      chk("const", data_out, 32'(ne[i]));
    end

    tag = "clamp_hi";
    set_wr(0, 32'h7FFF_FFFF, 16'hFFFF, 0, 255);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'h7FFF_FFFF);
    idle(4);
    chk("const", data_out, 32'h7FFF_FFFF);

    tag = "clamp_lo";
    set_wr(0, 32'h8000_0000, 16'hFFFF, 0, 255);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'h8000_0000);
    idle(4);
    chk("const", data_out, 32'h8000_0000);

    tag = "wrap";
    for (int c = 0; c < 8; c++) begin
      set_wr(c, 32'd0, 1, 0, c);
      cyc(1'b0, 1'b0, 32'd0);
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, i == 0, 32'd0);
    idle(4);
    chk("last_dat", data_out, 32'd1);
    chk("last_ch", 32'(data_out_ch), 32'd1);

    tag = "frame_start";
    for (int i = 0; i < 6; i++) cyc(1'b1, (i == 0) || (i == 3), 32'd0);
    idle(4);
    chk("last_dat", data_out, 32'd2);
    chk("last_ch", 32'(data_out_ch), 32'd2);

    tag = "midwrite";
    set_wr(0, 32'd10, 1, 0, 0);
    cyc(1'b1, 1'b1, 32'd5);
    idle(4);
    chk("old_bias", data_out, 32'd5);
    cyc(1'b1, 1'b1, 32'd5);
    idle(4);
    chk("new_bias", data_out, 32'd15);

    tag = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0)
        set_wr($urandom_range(0, 7), $urandom, $urandom_range(0, 65535),
               $urandom_range(0, 31), $urandom_range(0, 255));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
    end
    idle(4);

    tag = "reset_mid";
    set_wr(1, 32'd0, 1, 0, 7);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'd1);
    cyc(1'b1, 1'b0, 32'd1);
    cyc(1'b1, 1'b0, 32'd1);
    do_reset();
    idle(5);
    set_wr(0, 32'd0, 1, 0, 9);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd3);
    idle(4);
    chk("first_ch0", data_out, 32'd12);
    chk("first_ch0_ch", 32'(data_out_ch), 32'd0);
    cyc(1'b1, 1'b0, 32'd4);
    idle(4);
    chk("cleared_ch1", data_out, 32'd0);
    chk("cleared_ch1_ch", 32'(data_out_ch), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
